bp_nexus_packer: RTL and testbench
==================================

# bp_nexus_packer

Serializes the trace encoder's `nexus_trace_pkt_s` messages into a Nexus MDO/MSEO byte stream for the trace sink FIFO. It sits directly downstream of `bp_trace_encoder` and consumes its `trace_pkt_o`/`trace_valid_o`/`trace_ready_i` handshake. Each message becomes variable-length fields: TCODE, address/offset, timestamp. Leading-zero 6-bit chunks are suppressed.

## Interface
- `ADDR_W`, default 32: width of `addr`.
- `TS_W`, default 16: width of `timestamp`.
- `CNT_W`, default 16: width of the message counter.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; synchronous, active-high.
- `trace_pkt_i`  in  `nexus_trace_pkt_s`  fields used: `mcode` [5:0], `addr` [ADDR_W-1:0], `timestamp` [TS_W-1:0].
- `trace_valid_i`  in  1  packet valid.
- `trace_ready_o`  out  1  packer can accept a packet.
- `byte_o`  out  8  `{mdo[5:0], mseo[1:0]}`.
- `byte_valid_o`  out  1  `byte_o` valid.
- `byte_ready_i`  in  1  sink accepts the byte.
- `busy_o`  out  1  a message is in flight.
- `msg_count_o`  out  CNT_W  completed messages; wraps modulo 2^CNT_W.

## Operation
- MSEO codes:
  - 2'b00: more chunks follow in this field.
  - 2'b01: end of field.
  - 2'b11: end of message.
- A field is emitted as 6-bit chunks, LSB chunk first.
  - Chunk count = max(1, ceil((msb_index+1)/6)).
  - A zero value emits one chunk.
  - Maximum count is ceil(ADDR_W/6) for the address field (6 at 32) and ceil(TS_W/6) for the timestamp field (3 at 16).
- Message layout:
  - TCODE: one byte `{mcode, 2'b01}`.
  - Addr field: last chunk carries 2'b01.
  - Timestamp field: last chunk carries 2'b11.
- FSM states:
  - IDLE: `trace_ready_o`=1. On `trace_valid_i`, capture the packet and both chunk counts, then go to TCODE.
  - TCODE: go to ADDR on byte handshake.
  - ADDR: decrement the chunk index on each handshake; after the last addr chunk, go to TS.
  - TS: after the last ts chunk, increment `msg_count_o` and go to IDLE.
- `trace_ready_o` is high only in IDLE. Packets are never dropped. Upstream back-pressure is the only flow control.
- While `byte_valid_o && !byte_ready_i`, `byte_o` and all state hold.
- `busy_o` = (state != IDLE).

## Timing
- Reset values: state IDLE, `trace_ready_o`=1, `byte_valid_o`=0, `byte_o`=0, `busy_o`=0, `msg_count_o`=0.
- `byte_o` and `byte_valid_o` are registered outputs.
- Capture in cycle N gives the TCODE byte valid in N+1. With `byte_ready_i` held high, one byte is emitted per cycle.
- After the final byte handshake in cycle M:
  - `byte_valid_o`=0 and `trace_ready_o`=1 in M+1.
  - The next capture can occur at M+1 at the earliest.
  - There is one bubble between messages.
- Message length is 3 to 10 bytes (ADDR_W=32, TS_W=16).
- `msg_count_o` updates in the cycle after the final handshake.
- Reset asserted mid-message aborts the message: the partial message is discarded and all outputs return to reset values the next cycle.
- `trace_valid_i` outside IDLE is ignored; it is held upstream by `trace_ready_o`=0.

## Structure
- In `bp_nexus_defines`:
  - MSEO constants `NEXUS_MSEO_NORMAL`, `NEXUS_MSEO_EOF`, `NEXUS_MSEO_EOM`.
  - The packer state enum.
  - The chunk width constant (6).
- The `NEXUS_MCODE_*` values already in `bp_nexus_defines` are reused.
- Sub-module `bp_nexus_field_len`: purely combinational, parameterized width, computes the chunk count from a field value. Instantiated twice (addr, ts).

## Test plan
- DIRECT_BRANCH, addr=32'h8000_0000, ts=6, sink always ready:
  - Bytes `{DIRECT_BRANCH,01}`, 00, 00, 00, 00, 00, 09, 1B.
  - `msg_count_o`=1.
- COMPRESSED, addr=16, ts=3 → bytes `{COMPRESSED,01}`, 41, 0F. Exactly 3 bytes.
- addr=0, ts=0 → bytes `{mcode,01}`, 01, 03.
- Sink stall: drop `byte_ready_i` for 4 cycles mid-address. Required response:
  - `byte_o` stable and `byte_valid_o` high throughout.
  - Byte sequence identical to the unstalled run.
- Two back-to-back upstream packets (from the encoder):
  - Second captured exactly one cycle after the first message's final handshake.
  - `trace_ready_o` low throughout message 1.
- Reset asserted after the 2nd byte → next cycle IDLE, `byte_valid_o`=0, `msg_count_o`=0. A following packet serializes correctly from its TCODE byte.

Source files
------------

// File: rtl/bp_nexus_defines.sv
// Shared Nexus trace definitions: packet payload, MCODEs, MSEO codes, packer states.
package bp_nexus_defines;

   localparam int unsigned NEXUS_ADDR_W  = 32;
   localparam int unsigned NEXUS_TS_W    = 16;
   localparam int unsigned NEXUS_CHUNK_W = 6;

   localparam logic [5:0] NEXUS_MCODE_DIRECT_BRANCH   = 6'd3;
   localparam logic [5:0] NEXUS_MCODE_INDIRECT_BRANCH = 6'd4;
   localparam logic [5:0] NEXUS_MCODE_COMPRESSED      = 6'd33;

   localparam logic [1:0] NEXUS_MSEO_NORMAL = 2'b00;
   localparam logic [1:0] NEXUS_MSEO_EOF    = 2'b01;
   localparam logic [1:0] NEXUS_MSEO_EOM    = 2'b11;

   typedef enum logic [1:0] {
      NEXUS_ST_IDLE  = 2'd0,
      NEXUS_ST_TCODE = 2'd1,
      NEXUS_ST_ADDR  = 2'd2,
      NEXUS_ST_TS    = 2'd3
   } nexus_pack_state_e;

   typedef struct packed {
      logic [5:0]              mcode;
      logic [NEXUS_ADDR_W-1:0] addr;
      logic [NEXUS_TS_W-1:0]   timestamp;
   } nexus_trace_pkt_s;

   // Assemble one output byte: data chunk in the upper bits, MSEO in the lower two.
   function automatic logic [7:0] nexus_byte(input logic [5:0] chunk, input logic [1:0] mseo);
      return {chunk, mseo};
   endfunction

endpackage

// File: rtl/bp_nexus_field_len.sv
// Number of 6-bit chunks needed to carry a field value; zero still needs one chunk.
module bp_nexus_field_len
   import bp_nexus_defines::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned LEN_W = $clog2((W + NEXUS_CHUNK_W - 1) / NEXUS_CHUNK_W + 1)
)
(
   input  logic [W-1:0]     value,
   output logic [LEN_W-1:0] len_c
);

   localparam int unsigned NCH   = (W + NEXUS_CHUNK_W - 1) / NEXUS_CHUNK_W;
   localparam int unsigned PAD_W = NCH * NEXUS_CHUNK_W;

   logic [PAD_W-1:0] padded;

   // Highest non-zero chunk position determines the length.
   always_comb begin
      padded = PAD_W'(value);
      len_c  = LEN_W'(1);
      for (int unsigned i = 1; i < NCH; i++) begin
         if (padded[i*NEXUS_CHUNK_W +: NEXUS_CHUNK_W] != '0) begin
            len_c = LEN_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/bp_nexus_packer.sv
// Serializes trace packets into a Nexus MDO/MSEO byte stream (TCODE, addr, timestamp).
module bp_nexus_packer
   import bp_nexus_defines::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned TS_W   = 16,
   parameter int unsigned CNT_W  = 16
)
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  nexus_trace_pkt_s trace_pkt_i,
   input  logic             trace_valid_i,
   output logic             trace_ready_o,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] msg_count_o
);

   localparam int unsigned ADDR_CHUNKS = (ADDR_W + NEXUS_CHUNK_W - 1) / NEXUS_CHUNK_W;
   localparam int unsigned TS_CHUNKS   = (TS_W + NEXUS_CHUNK_W - 1) / NEXUS_CHUNK_W;
   localparam int unsigned ALEN_W      = $clog2(ADDR_CHUNKS + 1);
   localparam int unsigned TLEN_W      = $clog2(TS_CHUNKS + 1);

   logic [ALEN_W-1:0] addr_len_c;
   logic [TLEN_W-1:0] ts_len_c;
   logic              hs_c;

   nexus_pack_state_e state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [TS_W-1:0]   ts_q;
   logic [ALEN_W-1:0] addr_left_q;
   logic [TLEN_W-1:0] ts_left_q;

   bp_nexus_field_len #(.W(ADDR_W), .LEN_W(ALEN_W)) u_addr_len (
      .value (trace_pkt_i.addr[ADDR_W-1:0]),
      .len_c (addr_len_c)
   );

   bp_nexus_field_len #(.W(TS_W), .LEN_W(TLEN_W)) u_ts_len (
      .value (trace_pkt_i.timestamp[TS_W-1:0]),
      .len_c (ts_len_c)
   );

   assign hs_c = byte_valid_o && byte_ready_i;

   // Packer FSM; *_left_q counts chunks still to be emitted after the current byte.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= NEXUS_ST_IDLE;
         addr_q        <= '0;
         ts_q          <= '0;
         addr_left_q   <= '0;
         ts_left_q     <= '0;
         trace_ready_o <= 1'b1;
         byte_o        <= '0;
         byte_valid_o  <= 1'b0;
         busy_o        <= 1'b0;
         msg_count_o   <= '0;
      end else begin
         case (state_q)
            NEXUS_ST_IDLE: begin
               if (trace_valid_i) begin
                  addr_q        <= trace_pkt_i.addr[ADDR_W-1:0];
                  ts_q          <= trace_pkt_i.timestamp[TS_W-1:0];
                  addr_left_q   <= addr_len_c - ALEN_W'(1);
                  ts_left_q     <= ts_len_c - TLEN_W'(1);
                  byte_o        <= nexus_byte(trace_pkt_i.mcode, NEXUS_MSEO_EOF);
                  byte_valid_o  <= 1'b1;
                  trace_ready_o <= 1'b0;
                  busy_o        <= 1'b1;
                  state_q       <= NEXUS_ST_TCODE;
               end
            end

            NEXUS_ST_TCODE: begin
               if (hs_c) begin
                  byte_o  <= nexus_byte(addr_q[NEXUS_CHUNK_W-1:0],
                                        (addr_left_q == '0) ? NEXUS_MSEO_EOF : NEXUS_MSEO_NORMAL);
                  addr_q  <= addr_q >> NEXUS_CHUNK_W;
                  state_q <= NEXUS_ST_ADDR;
               end
            end

            NEXUS_ST_ADDR: begin
               if (hs_c) begin
                  if (addr_left_q == '0) begin
                     byte_o  <= nexus_byte(ts_q[NEXUS_CHUNK_W-1:0],
                                           (ts_left_q == '0) ? NEXUS_MSEO_EOM : NEXUS_MSEO_NORMAL);
                     ts_q    <= ts_q >> NEXUS_CHUNK_W;
                     state_q <= NEXUS_ST_TS;
                  end else begin
                     byte_o      <= nexus_byte(addr_q[NEXUS_CHUNK_W-1:0],
                                               (addr_left_q == ALEN_W'(1)) ? NEXUS_MSEO_EOF
                                                                           : NEXUS_MSEO_NORMAL);
                     addr_q      <= addr_q >> NEXUS_CHUNK_W;
                     addr_left_q <= addr_left_q - ALEN_W'(1);
                  end
               end
            end

            NEXUS_ST_TS: begin
               if (hs_c) begin
                  if (ts_left_q == '0) begin
                     byte_o        <= '0;
                     byte_valid_o  <= 1'b0;
                     trace_ready_o <= 1'b1;
                     busy_o        <= 1'b0;
                     msg_count_o   <= msg_count_o + CNT_W'(1);
                     state_q       <= NEXUS_ST_IDLE;
                  end else begin
                     byte_o    <= nexus_byte(ts_q[NEXUS_CHUNK_W-1:0],
                                             (ts_left_q == TLEN_W'(1)) ? NEXUS_MSEO_EOM
                                                                       : NEXUS_MSEO_NORMAL);
                     ts_q      <= ts_q >> NEXUS_CHUNK_W;
                     ts_left_q <= ts_left_q - TLEN_W'(1);
                  end
               end
            end

            default: begin
               state_q <= NEXUS_ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_nexus_packer.sv
// Randomized and directed bench for bp_nexus_packer against a byte-list reference model.
module tb_bp_nexus_packer;
   import bp_nexus_defines::*;

   logic             clk_i = 1'b0;
   logic             reset_i;
   nexus_trace_pkt_s trace_pkt_i;
   logic             trace_valid_i;
   logic             trace_ready_o;
   logic [7:0]       byte_o;
   logic             byte_valid_o;
   logic             byte_ready_i;
   logic             busy_o;
   logic [15:0]      msg_count_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_fin_cyc = -100;
   int model_count = 0;
   logic [7:0] last_got[$];

   bp_nexus_packer #(.ADDR_W(32), .TS_W(16), .CNT_W(16)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .trace_pkt_i   (trace_pkt_i),
      .trace_valid_i (trace_valid_i),
      .trace_ready_o (trace_ready_o),
      .byte_o        (byte_o),
      .byte_valid_o  (byte_valid_o),
      .byte_ready_i  (byte_ready_i),
      .busy_o        (busy_o),
      .msg_count_o   (msg_count_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Chunks needed for a value: bit length rounded up to 6, never fewer than one.
   function automatic int nchunks(input logic [63:0] v);
      int bits = 0;
      while (bits < 64 && (v >> bits) != 64'd0) bits++;
      return (bits == 0) ? 1 : (bits + 5) / 6;
   endfunction

   task automatic build_expected(input logic [5:0] mc, input logic [31:0] a, input logic [15:0] t,
                                 output logic [7:0] q[$]);
      int na = nchunks(64'(a));
      int nt = nchunks(64'(t));
      q = {};
      q.push_back({mc, 2'b01});
      for (int i = 0; i < na; i++)
         q.push_back({6'((64'(a) >> (6 * i)) & 64'd63), (i == na - 1) ? 2'b01 : 2'b00});
      for (int i = 0; i < nt; i++)
         q.push_back({6'((64'(t) >> (6 * i)) & 64'd63), (i == nt - 1) ? 2'b11 : 2'b00});
   endtask

   // Present one packet at a negedge and drain its bytes; optional stall window, random
   // sink back-pressure, back-to-back capture check, or reset after abort_after bytes.
   task automatic run_msg(input logic [5:0] mc, input logic [31:0] a, input logic [15:0] t,
                          input int stall_at, input int stall_len, input bit rand_ready,
                          input bit expect_b2b, input int abort_after);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      logic [7:0] held = 8'h00;
      int  budget = 0;
      int  hs = 0;
      int  stall_rem = stall_len;
      int  cap_cyc;
      bit  stalled = 1'b0;
      bit  ready_hi = 1'b0;
      bit  done = 1'b0;
      bit  aborted = 1'b0;

      build_expected(mc, a, t, exp_q);
      trace_pkt_i.mcode     = mc;
      trace_pkt_i.addr      = a;
      trace_pkt_i.timestamp = t;
      trace_valid_i         = 1'b1;
      while (!trace_ready_o && budget < 50) begin
         @(negedge clk_i);
         budget++;
      end
      if (!trace_ready_o) begin
         check("capture_timeout", 64'd0, 64'd1);
         trace_valid_i = 1'b0;
         return;
      end
      cap_cyc = cyc + 1;
      if (expect_b2b) check("b2b_capture_cycle", 64'(cap_cyc), 64'(last_fin_cyc + 1));
      @(negedge clk_i);
      trace_valid_i = 1'b0;
      check("tcode_valid", 64'(byte_valid_o), 64'd1);
      check("tcode_byte", 64'(byte_o), 64'(exp_q[0]));
      check("busy", 64'(busy_o), 64'd1);

      budget = 0;
      while (!done && !aborted && budget < 300) begin
         if (stalled) begin
            check("stall_valid", 64'(byte_valid_o), 64'd1);
            check("stall_hold", 64'(byte_o), 64'(held));
         end
         if (trace_ready_o) ready_hi = 1'b1;
         if (hs == stall_at && stall_rem > 0) begin
            byte_ready_i = 1'b0;
            stall_rem--;
         end else begin
            byte_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         stalled = byte_valid_o && !byte_ready_i;
         held    = byte_o;
         if (byte_valid_o && byte_ready_i) begin
            got_q.push_back(byte_o);
            hs++;
            if (byte_o[1:0] == 2'b11) begin
               done = 1'b1;
               last_fin_cyc = cyc + 1;
            end
            if (abort_after > 0 && hs == abort_after) aborted = 1'b1;
         end
         @(negedge clk_i);
         budget++;
      end
      byte_ready_i = 1'b1;

      if (aborted) begin
         reset_i = 1'b1;
         @(negedge clk_i);
         reset_i = 1'b0;
         model_count = 0;
         check("abort_valid", 64'(byte_valid_o), 64'd0);
         check("abort_ready", 64'(trace_ready_o), 64'd1);
         check("abort_busy", 64'(busy_o), 64'd0);
         check("abort_byte", 64'(byte_o), 64'd0);
         check("abort_count", 64'(msg_count_o), 64'd0);
         return;
      end
      if (!done) begin
         check("drain_timeout", 64'd0, 64'd1);
         return;
      end
      model_count++;
      check("end_valid", 64'(byte_valid_o), 64'd0);
      check("end_ready", 64'(trace_ready_o), 64'd1);
      check("end_busy", 64'(busy_o), 64'd0);
      check("msg_count", 64'(msg_count_o), 64'(model_count & 16'hFFFF));
      check("ready_low_in_msg", 64'(ready_hi), 64'd0);
      check("msg_len", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      last_got = got_q;
   endtask

   initial begin
      reset_i       = 1'b1;
      trace_valid_i = 1'b0;
      trace_pkt_i   = '0;
      byte_ready_i  = 1'b1;
      repeat (3) @(negedge clk_i);
      reset_i = 1'b0;
      check("rst_ready", 64'(trace_ready_o), 64'd1);
      check("rst_valid", 64'(byte_valid_o), 64'd0);
      check("rst_byte", 64'(byte_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_count", 64'(msg_count_o), 64'd0);
      @(negedge clk_i);

      // Direct branch with top address bit set: 8 bytes, last addr chunk 0x09, ts 0x1B.
      run_msg(NEXUS_MCODE_DIRECT_BRANCH, 32'h8000_0000, 16'd6, -1, 0, 1'b0, 1'b0, 0);
      check("db_len", 64'(last_got.size()), 64'd8);
      if (last_got.size() == 8) begin
         check("db_addr_last", 64'(last_got[6]), 64'h09);
         check("db_ts", 64'(last_got[7]), 64'h1B);
      end
      check("db_count", 64'(msg_count_o), 64'd1);
      @(negedge clk_i);

      // Short message: exactly 3 bytes.
      run_msg(NEXUS_MCODE_COMPRESSED, 32'd16, 16'd3, -1, 0, 1'b0, 1'b0, 0);
      check("cmp_len", 64'(last_got.size()), 64'd3);
      if (last_got.size() == 3) begin
         check("cmp_addr", 64'(last_got[1]), 64'h41);
         check("cmp_ts", 64'(last_got[2]), 64'h0F);
      end
      @(negedge clk_i);

      // Zero fields still emit one chunk each.
      run_msg(NEXUS_MCODE_INDIRECT_BRANCH, 32'd0, 16'd0, -1, 0, 1'b0, 1'b0, 0);
      if (last_got.size() == 3) begin
         check("zero_addr", 64'(last_got[1]), 64'h01);
         check("zero_ts", 64'(last_got[2]), 64'h03);
      end
      @(negedge clk_i);

      // Four-cycle sink stall in the middle of the address field.
      run_msg(NEXUS_MCODE_DIRECT_BRANCH, 32'hFFFF_FFFF, 16'hFFFF, 3, 4, 1'b0, 1'b0, 0);

      // Back-to-back packets: second captured one cycle after the first's final byte.
      run_msg(NEXUS_MCODE_COMPRESSED, 32'h0001_2345, 16'h0ABC, -1, 0, 1'b0, 1'b0, 0);
      run_msg(NEXUS_MCODE_DIRECT_BRANCH, 32'h00FF_0000, 16'h0040, -1, 0, 1'b0, 1'b1, 0);

      // Reset after the second byte, then a clean message.
      run_msg(NEXUS_MCODE_DIRECT_BRANCH, 32'hDEAD_BEEF, 16'h1234, -1, 0, 1'b0, 1'b0, 2);
      run_msg(NEXUS_MCODE_INDIRECT_BRANCH, 32'h0000_0FC0, 16'h0001, -1, 0, 1'b0, 1'b0, 0);
      check("post_abort_count", 64'(msg_count_o), 64'd1);

      // Random packets with random sink back-pressure and random gaps.
      for (int k = 0; k < 60; k++) begin
         logic [5:0]  mc;
         logic [31:0] a;
         logic [15:0] t;
         bit          gap;
         mc  = 6'($urandom);
         a   = $urandom >> $urandom_range(0, 32);
         t   = 16'($urandom >> $urandom_range(0, 16));
         gap = ($urandom_range(0, 1) == 1);
         if (gap) repeat ($urandom_range(1, 3)) @(negedge clk_i);
         run_msg(mc, a, t, -1, 0, 1'b1, !gap && (k > 0), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
